axi4_burst_ram: RTL and testbench

- AXI4 full-protocol slave backed by a single on-chip word array.
- Serves the memory-mapped host/DMA path in system-level emulation benches: loading and capturing checkpoint images, and serving DUT memory.
- Read and write channels are independent; supports INCR/FIXED bursts up to 256 beats.
- Storage array is named mem, indexed by word address, so benches can access it hierarchically.

---
 rtl/axi4_burst_ram_pkg.sv | 20 ++
 rtl/axi4_burst_ram.sv | 201 ++++++++++++++++++++
 tb/tb_axi4_burst_ram.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi4_burst_ram_pkg.sv
// Shared constants and FSM state types for the AXI4 burst RAM slave.
package axi4_burst_ram_pkg;

    localparam logic [1:0] BURST_FIXED = 2'd0;
    localparam logic [1:0] BURST_INCR  = 2'd1;
    localparam logic [1:0] BURST_WRAP  = 2'd2;
    localparam logic [1:0] RESP_OKAY   = 2'd0;

    typedef enum logic [1:0] {
        W_IDLE  = 2'd0,
        W_BURST = 2'd1,
        W_RESP  = 2'd2
    } wstate_t;

    typedef enum logic {
        R_IDLE  = 1'b0,
        R_BURST = 1'b1
    } rstate_t;

endpackage

// File: rtl/axi4_burst_ram.sv
// AXI4 slave over a single word array; independent write and read burst FSMs.
module axi4_burst_ram
    import axi4_burst_ram_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8,
    parameter int unsigned ID_WIDTH   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ID_WIDTH-1:0]   s_axi_awid,
    input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
    input  logic [7:0]            s_axi_awlen,
    input  logic [2:0]            s_axi_awsize,
    input  logic [1:0]            s_axi_awburst,
    input  logic                  s_axi_awlock,
    input  logic [3:0]            s_axi_awcache,
    input  logic [2:0]            s_axi_awprot,
    input  logic                  s_axi_awvalid,
    output logic                  s_axi_awready,
    input  logic [DATA_WIDTH-1:0] s_axi_wdata,
    input  logic [STRB_WIDTH-1:0] s_axi_wstrb,
    input  logic                  s_axi_wlast,
    input  logic                  s_axi_wvalid,
    output logic                  s_axi_wready,
    output logic [ID_WIDTH-1:0]   s_axi_bid,
    output logic [1:0]            s_axi_bresp,
    output logic                  s_axi_bvalid,
    input  logic                  s_axi_bready,
    input  logic [ID_WIDTH-1:0]   s_axi_arid,
    input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic [7:0]            s_axi_arlen,
    input  logic [2:0]            s_axi_arsize,
    input  logic [1:0]            s_axi_arburst,
    input  logic                  s_axi_arlock,
    input  logic [3:0]            s_axi_arcache,
    input  logic [2:0]            s_axi_arprot,
    input  logic                  s_axi_arvalid,
    output logic                  s_axi_arready,
    output logic [ID_WIDTH-1:0]   s_axi_rid,
    output logic [DATA_WIDTH-1:0] s_axi_rdata,
    output logic [1:0]            s_axi_rresp,
    output logic                  s_axi_rlast,
    output logic                  s_axi_rvalid,
    input  logic                  s_axi_rready
);

    localparam int unsigned ADDR_LSB = $clog2(STRB_WIDTH);
    localparam int unsigned WORD_AW  = ADDR_WIDTH - ADDR_LSB;
    localparam int unsigned DEPTH    = 2 ** WORD_AW;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Address arithmetic wraps modulo the byte address space, i.e. modulo mem.
    function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a,
                                                        input logic [2:0]            size,
                                                        input logic [1:0]            burst);
        return (burst == BURST_FIXED) ? a : a + (ADDR_WIDTH'(1) << size);
    endfunction

    wstate_t               r_wstate, w_wstate_nxt;
    logic [ADDR_WIDTH-1:0] r_waddr;
    logic [7:0]            r_wcnt;
    logic [2:0]            r_wsize;
    logic [1:0]            r_wburst;
    logic                  r_awready, r_wready, r_bvalid;
    logic [ID_WIDTH-1:0]   r_bid;
    logic                  w_aw_hs, w_wbeat, w_b_hs;

    rstate_t               r_rstate, w_rstate_nxt;
    logic [ADDR_WIDTH-1:0] r_raddr;
    logic [7:0]            r_rcnt;
    logic [2:0]            r_rsize;
    logic [1:0]            r_rburst;
    logic                  r_arready, r_rvalid, r_rlast;
    logic [ID_WIDTH-1:0]   r_rid;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  w_ar_hs, w_r_hs;

    logic                  w_unused;

    assign w_unused = ^{s_axi_awlock, s_axi_awcache, s_axi_awprot, s_axi_wlast,
                        s_axi_arlock, s_axi_arcache, s_axi_arprot};

    assign w_aw_hs = s_axi_awvalid && r_awready;
    assign w_wbeat = s_axi_wvalid && r_wready && !rst;
    assign w_b_hs  = r_bvalid && s_axi_bready;
    assign w_ar_hs = s_axi_arvalid && r_arready;
    assign w_r_hs  = r_rvalid && s_axi_rready;

    // Write FSM next state; the beat counter, not wlast, closes the burst.
    always_comb begin
        w_wstate_nxt = r_wstate;
        case (r_wstate)
            W_IDLE:  if (w_aw_hs) w_wstate_nxt = W_BURST;
            W_BURST: if (w_wbeat && r_wcnt == 8'd0) w_wstate_nxt = W_RESP;
            W_RESP:  if (w_b_hs) w_wstate_nxt = W_IDLE;
            default: w_wstate_nxt = W_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wstate  <= W_IDLE;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b0;
            r_bid     <= '0;
            r_waddr   <= '0;
            r_wcnt    <= '0;
            r_wsize   <= '0;
            r_wburst  <= '0;
        end else begin
            r_wstate  <= w_wstate_nxt;
            r_awready <= (w_wstate_nxt == W_IDLE);
            r_wready  <= (w_wstate_nxt == W_BURST);
            r_bvalid  <= (w_wstate_nxt == W_RESP);
            if (w_aw_hs) begin
                r_waddr  <= s_axi_awaddr;
                r_wcnt   <= s_axi_awlen;
                r_wsize  <= s_axi_awsize;
                r_wburst <= s_axi_awburst;
                r_bid    <= s_axi_awid;
            end else if (w_wbeat) begin
                r_waddr <= next_addr(r_waddr, r_wsize, r_wburst);
                r_wcnt  <= r_wcnt - 8'd1;
            end
        end
    end

    // Storage is deliberately outside reset so checkpoint contents survive rst.
    always_ff @(posedge clk) begin
        if (w_wbeat) begin
            for (int i = 0; i < STRB_WIDTH; i++) begin
                if (s_axi_wstrb[i]) begin
                    mem[r_waddr[ADDR_WIDTH-1:ADDR_LSB]][i*8 +: 8] <= s_axi_wdata[i*8 +: 8];
                end
            end
        end
    end

    always_comb begin
        w_rstate_nxt = r_rstate;
        case (r_rstate)
            R_IDLE:  if (w_ar_hs) w_rstate_nxt = R_BURST;
            R_BURST: if (w_r_hs && r_rlast) w_rstate_nxt = R_IDLE;
        endcase
    end

    // Read beats are fetched one cycle ahead; a same-cycle write is not yet visible.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rstate  <= R_IDLE;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rlast   <= 1'b0;
            r_rid     <= '0;
            r_rdata   <= '0;
            r_raddr   <= '0;
            r_rcnt    <= '0;
            r_rsize   <= '0;
            r_rburst  <= '0;
        end else begin
            r_rstate  <= w_rstate_nxt;
            r_arready <= (w_rstate_nxt == R_IDLE);
            r_rvalid  <= (w_rstate_nxt == R_BURST);
            if (w_ar_hs) begin
                r_rdata  <= mem[s_axi_araddr[ADDR_WIDTH-1:ADDR_LSB]];
                r_rlast  <= (s_axi_arlen == 8'd0);
                r_rid    <= s_axi_arid;
                r_rcnt   <= s_axi_arlen;
                r_rsize  <= s_axi_arsize;
                r_rburst <= s_axi_arburst;
                r_raddr  <= next_addr(s_axi_araddr, s_axi_arsize, s_axi_arburst);
            end else if (w_r_hs) begin
                if (r_rlast) begin
                    r_rlast <= 1'b0;
                end else begin
                    r_rdata <= mem[r_raddr[ADDR_WIDTH-1:ADDR_LSB]];
                    r_rlast <= (r_rcnt == 8'd1);
                    r_rcnt  <= r_rcnt - 8'd1;
                    r_raddr <= next_addr(r_raddr, r_rsize, r_rburst);
                end
            end
        end
    end

    assign s_axi_awready = r_awready;
    assign s_axi_wready  = r_wready;
    assign s_axi_bvalid  = r_bvalid;
    assign s_axi_bid     = r_bid;
    assign s_axi_bresp   = RESP_OKAY;
    assign s_axi_arready = r_arready;
    assign s_axi_rvalid  = r_rvalid;
    assign s_axi_rlast   = r_rlast;
    assign s_axi_rid     = r_rid;
    assign s_axi_rdata   = r_rdata;
    assign s_axi_rresp   = RESP_OKAY;

endmodule

// File: tb/tb_axi4_burst_ram.sv
// Randomized bench for axi4_burst_ram against a word-array reference model.
module tb_axi4_burst_ram;

    localparam int unsigned DW    = 64;
    localparam int unsigned AW    = 16;
    localparam int unsigned IW    = 1;
    localparam int unsigned SW    = DW / 8;
    localparam int unsigned DEPTH = 8192;
    localparam int unsigned TMO   = 200;

    logic          clk = 1'b0;
    logic          rst;
    logic [IW-1:0] s_axi_awid, s_axi_bid, s_axi_arid, s_axi_rid;
    logic [AW-1:0] s_axi_awaddr, s_axi_araddr;
    logic [7:0]    s_axi_awlen, s_axi_arlen;
    logic [2:0]    s_axi_awsize, s_axi_arsize, s_axi_awprot, s_axi_arprot;
    logic [1:0]    s_axi_awburst, s_axi_arburst, s_axi_bresp, s_axi_rresp;
    logic          s_axi_awlock, s_axi_arlock;
    logic [3:0]    s_axi_awcache, s_axi_arcache;
    logic          s_axi_awvalid, s_axi_awready, s_axi_wlast, s_axi_wvalid, s_axi_wready;
    logic          s_axi_bvalid, s_axi_bready, s_axi_arvalid, s_axi_arready;
    logic          s_axi_rlast, s_axi_rvalid, s_axi_rready;
    logic [DW-1:0] s_axi_wdata, s_axi_rdata;
    logic [SW-1:0] s_axi_wstrb;

    int            checks   = 0;
    int            failures = 0;
    logic [DW-1:0] model [DEPTH];
    logic [DW-1:0] wdat  [256];
    logic [SW-1:0] wstb  [256];

    always #5 clk = ~clk;

    axi4_burst_ram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STRB_WIDTH(SW), .ID_WIDTH(IW)) dut (
        .clk(clk), .rst(rst),
        .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
        .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst), .s_axi_awlock(s_axi_awlock),
        .s_axi_awcache(s_axi_awcache), .s_axi_awprot(s_axi_awprot), .s_axi_awvalid(s_axi_awvalid),
        .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
        .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
        .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
        .s_axi_bready(s_axi_bready),
        .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
        .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst), .s_axi_arlock(s_axi_arlock),
        .s_axi_arcache(s_axi_arcache), .s_axi_arprot(s_axi_arprot), .s_axi_arvalid(s_axi_arvalid),
        .s_axi_arready(s_axi_arready),
        .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
        .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready)
    );

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [AW-1:0] step(input logic [AW-1:0] a, input logic [2:0] size,
                                           input logic [1:0] burst);
        return (burst == 2'd0) ? a : a + (AW'(1) << size);
    endfunction

    function automatic void model_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                                        input logic [SW-1:0] s);
        for (int b = 0; b < SW; b++) begin
            if (s[b]) model[a[AW-1:3]][b*8 +: 8] = d[b*8 +: 8];
        end
    endfunction

    // Sends nbeats of wdat/wstb; a short count leaves the burst open (used before a reset).
    task automatic axi_write(input logic [AW-1:0] addr, input int len, input logic [2:0] size,
                             input logic [1:0] burst, input logic [IW-1:0] id, input int bdelay,
                             input int nbeats);
        logic [AW-1:0] a;
        int            n;
        a             = addr;
        s_axi_awaddr  = addr;
        s_axi_awlen   = 8'(len);
        s_axi_awsize  = size;
        s_axi_awburst = burst;
        s_axi_awid    = id;
        s_axi_awlock  = 1'($urandom);
        s_axi_awcache = 4'($urandom);
        s_axi_awprot  = 3'($urandom);
        s_axi_awvalid = 1'b1;
        n = 0;
        while (!s_axi_awready && n < TMO) begin @(posedge clk); #1; n++; end
        if (n >= TMO) begin check("aw_timeout", 0, 1); s_axi_awvalid = 1'b0; return; end
        @(posedge clk); #1;
        s_axi_awvalid = 1'b0;
        for (int i = 0; i < nbeats; i++) begin
            if ($urandom_range(0, 3) == 0) begin s_axi_wvalid = 1'b0; @(posedge clk); #1; end
            s_axi_wdata  = wdat[i];
            s_axi_wstrb  = wstb[i];
            s_axi_wlast  = (i == len);
            s_axi_wvalid = 1'b1;
            n = 0;
            while (!s_axi_wready && n < TMO) begin @(posedge clk); #1; n++; end
            if (n >= TMO) begin check("w_timeout", 0, 1); break; end
            @(posedge clk); #1;
            model_write(a, wdat[i], wstb[i]);
            a = step(a, size, burst);
        end
        s_axi_wvalid = 1'b0;
        s_axi_wlast  = 1'b0;
        if (nbeats <= len) return;
        n = 0;
        while (!s_axi_bvalid && n < TMO) begin @(posedge clk); #1; n++; end
        check("b_latency", 64'(n <= 2), 1);
        for (int k = 0; k < bdelay; k++) begin
            check("b_hold_valid", s_axi_bvalid, 1);
            check("b_hold_awready", s_axi_awready, 0);
            @(posedge clk); #1;
        end
        check("bresp", s_axi_bresp, 0);
        check("bid", s_axi_bid, id);
        s_axi_bready = 1'b1;
        @(posedge clk); #1;
        s_axi_bready = 1'b0;
        check("b_done_bvalid", s_axi_bvalid, 0);
        check("awready_back", s_axi_awready, 1);
    endtask

    task automatic axi_read(input logic [AW-1:0] addr, input int len, input logic [2:0] size,
                            input logic [1:0] burst, input logic [IW-1:0] id,
                            input int stall_beat, input int stall_len, input bit rnd);
        logic [DW-1:0] exp [$];
        logic [DW-1:0] held;
        logic [AW-1:0] a;
        int            n, stalls;
        a = addr;
        for (int i = 0; i <= len; i++) begin exp.push_back(model[a[AW-1:3]]); a = step(a, size, burst); end
        s_axi_araddr  = addr;
        s_axi_arlen   = 8'(len);
        s_axi_arsize  = size;
        s_axi_arburst = burst;
        s_axi_arid    = id;
        s_axi_arlock  = 1'($urandom);
        s_axi_arcache = 4'($urandom);
        s_axi_arprot  = 3'($urandom);
        s_axi_arvalid = 1'b1;
        n = 0;
        while (!s_axi_arready && n < TMO) begin @(posedge clk); #1; n++; end
        if (n >= TMO) begin check("ar_timeout", 0, 1); s_axi_arvalid = 1'b0; return; end
        @(posedge clk); #1;
        s_axi_arvalid = 1'b0;
        check("r_first_valid", s_axi_rvalid, 1);
        for (int i = 0; i <= len; i++) begin
            stalls = (i == stall_beat) ? stall_len :
                     (rnd && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
            held = s_axi_rdata;
            for (int k = 0; k < stalls; k++) begin
                s_axi_rready = 1'b0;
                @(posedge clk); #1;
                check("r_hold_valid", s_axi_rvalid, 1);
                check("r_hold_data", s_axi_rdata, held);
            end
            check("r_valid", s_axi_rvalid, 1);
            check("r_data", s_axi_rdata, exp[i]);
            check("r_last", s_axi_rlast, 64'(i == len));
            check("r_id", s_axi_rid, id);
            check("r_resp", s_axi_rresp, 0);
            s_axi_rready = 1'b1;
            @(posedge clk); #1;
            s_axi_rready = 1'b0;
        end
        check("r_end_valid", s_axi_rvalid, 0);
        check("r_arready_back", s_axi_arready, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [AW-1:0] ra;
        int            rl;
        logic [2:0]    rs;
        logic [1:0]    rb;
        logic [IW-1:0] rid;
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        rst = 1'b1;
        {s_axi_awid, s_axi_awaddr, s_axi_awlen, s_axi_awsize, s_axi_awburst, s_axi_awlock,
         s_axi_awcache, s_axi_awprot, s_axi_awvalid} = '0;
        {s_axi_wdata, s_axi_wstrb, s_axi_wlast, s_axi_wvalid, s_axi_bready} = '0;
        {s_axi_arid, s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst, s_axi_arlock,
         s_axi_arcache, s_axi_arprot, s_axi_arvalid, s_axi_rready} = '0;

        repeat (5) @(posedge clk);
        #1;
        check("rst_awready", s_axi_awready, 0);
        check("rst_arready", s_axi_arready, 0);
        check("rst_wready", s_axi_wready, 0);
        check("rst_bvalid", s_axi_bvalid, 0);
        check("rst_rvalid", s_axi_rvalid, 0);
        check("rst_rlast", s_axi_rlast, 0);
        check("rst_rdata", s_axi_rdata, 0);
        check("rst_ids", {s_axi_bid, s_axi_rid}, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("post_rst_awready", s_axi_awready, 1);
        check("post_rst_arready", s_axi_arready, 1);
        check("post_rst_bvalid", s_axi_bvalid, 0);
        check("post_rst_rvalid", s_axi_rvalid, 0);

        // Single beat
        wdat[0] = 64'h1122334455667788; wstb[0] = 8'hFF;
        axi_write(16'h0010, 0, 3'd3, 2'd1, 1'b0, 0, 1);
        axi_read(16'h0010, 0, 3'd3, 2'd1, 1'b0, -1, 0, 1'b0);

        // INCR burst of four, rready held high
        for (int i = 0; i < 4; i++) begin wdat[i] = 64'(i + 1); wstb[i] = 8'hFF; end
        axi_write(16'h0100, 3, 3'd3, 2'd1, 1'b1, 0, 4);
        axi_read(16'h0100, 3, 3'd3, 2'd1, 1'b1, -1, 0, 1'b0);
        for (int i = 0; i < 4; i++) check("mem_incr", dut.mem[32'h20 + i], 64'(i + 1));

        // Byte strobes
        wdat[0] = '1; wstb[0] = 8'hFF;
        axi_write(16'h0200, 0, 3'd3, 2'd1, 1'b0, 0, 1);
        wdat[0] = '0; wstb[0] = 8'h0F;
        axi_write(16'h0200, 0, 3'd3, 2'd1, 1'b0, 0, 1);
        check("mem_strobe", dut.mem[32'h40], 64'hFFFFFFFF00000000);
        axi_read(16'h0200, 0, 3'd3, 2'd1, 1'b0, -1, 0, 1'b0);

        // FIXED burst: both beats land on one word
        wdat[0] = 64'hAAAA_0000_AAAA_0001; wdat[1] = 64'hBBBB_0000_BBBB_0002;
        wstb[0] = 8'hFF; wstb[1] = 8'hFF;
        axi_write(16'h0300, 1, 3'd3, 2'd0, 1'b1, 0, 2);
        check("mem_fixed", dut.mem[32'h60], 64'hBBBB_0000_BBBB_0002);
        axi_read(16'h0300, 0, 3'd3, 2'd1, 1'b1, -1, 0, 1'b0);

        // Backpressure on B and R
        for (int i = 0; i < 4; i++) begin wdat[i] = 64'($urandom) << 32 | 64'($urandom); wstb[i] = 8'hFF; end
        axi_write(16'h0400, 3, 3'd3, 2'd1, 1'b0, 3, 4);
        axi_read(16'h0400, 3, 3'd3, 2'd1, 1'b0, 1, 3, 1'b0);

        // Reset after two of four beats
        for (int i = 0; i < 4; i++) begin wdat[i] = 64'hC0DE_0000_0000_0000 | 64'(i); wstb[i] = 8'hFF; end
        axi_write(16'h0500, 3, 3'd3, 2'd1, 1'b0, 0, 2);
        rst = 1'b1;
        repeat (2) begin @(posedge clk); #1; check("midrst_bvalid", s_axi_bvalid, 0); end
        rst = 1'b0;
        @(posedge clk); #1;
        check("midrst_awready", s_axi_awready, 1);
        check("midrst_arready", s_axi_arready, 1);
        check("midrst_wready", s_axi_wready, 0);
        check("midrst_bvalid_after", s_axi_bvalid, 0);
        check("midrst_mem0", dut.mem[32'hA0], wdat[0]);
        check("midrst_mem1", dut.mem[32'hA1], wdat[1]);
        check("midrst_mem2", dut.mem[32'hA2], 0);
        axi_read(16'h0500, 3, 3'd3, 2'd1, 1'b0, -1, 0, 1'b0);

        // INCR burst across the top of the array
        for (int i = 0; i < 8; i++) begin wdat[i] = 64'hF00D_0000_0000_0000 | 64'(i); wstb[i] = 8'hFF; end
        axi_write(16'hFFE0, 7, 3'd3, 2'd1, 1'b1, 0, 8);
        check("mem_wrap", dut.mem[0], 64'hF00D_0000_0000_0004);
        axi_read(16'hFFE0, 7, 3'd3, 2'd1, 1'b1, -1, 0, 1'b1);
        axi_read(16'h0000, 3, 3'd3, 2'd1, 1'b0, -1, 0, 1'b1);

        // Concurrent write and read to disjoint regions
        for (int i = 0; i < 6; i++) begin wdat[i] = 64'($urandom) << 32 | 64'($urandom); wstb[i] = 8'hFF; end
        fork
            axi_write(16'h2000, 5, 3'd3, 2'd1, 1'b1, 1, 6);
            axi_read(16'h0100, 3, 3'd3, 2'd1, 1'b0, -1, 0, 1'b1);
        join

        // Random bursts: sizes, burst types, strobes, unaligned addresses
        repeat (25) begin
            ra  = AW'($urandom);
            rl  = int'($urandom_range(0, 15));
            rs  = 3'($urandom_range(0, 3));
            rb  = 2'($urandom_range(0, 2));
            rid = IW'($urandom);
            for (int i = 0; i <= rl; i++) begin
                wdat[i] = 64'($urandom) << 32 | 64'($urandom);
                wstb[i] = ($urandom_range(0, 1) == 0) ? 8'hFF : 8'($urandom);
            end
            axi_write(ra, rl, rs, rb, rid, int'($urandom_range(0, 2)), rl + 1);
            axi_read(ra, rl, rs, rb, ~rid, -1, 0, 1'b1);
            if ($urandom_range(0, 1) == 0)
                axi_read(ra, int'($urandom_range(0, 7)), 3'd3, 2'd1, rid, -1, 0, 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
